// File: rtl/renkon_bias_bank.sv
// Multi-lane saturating bias adder with a bias memory, a LANE-wide shadow fetch
// and an atomic shadow-to-active swap, followed by optional ReLU.
module renkon_bias_bank #(
  parameter int DWIDTH = 16,
  parameter int LANE   = 8,
  parameter int BDEPTH = 32,
  parameter int AWIDTH = $clog2(BDEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bias_we,
  input  logic [AWIDTH-1:0]      bias_addr,
  input  logic [DWIDTH-1:0]      bias_wdata,
  input  logic                   bsel_en,
  input  logic [AWIDTH-1:0]      bsel_base,
  output logic                   busy,
  input  logic                   relu_en,
  input  logic                   in_valid,
  input  logic [LANE*DWIDTH-1:0] pixel_in,
  output logic                   out_valid,
  output logic [LANE*DWIDTH-1:0] pixel_out
);

  localparam int KWIDTH = (LANE > 1) ? $clog2(LANE) : 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                  state_q, state_d;
  logic [AWIDTH-1:0]       base_q, base_d;
  logic [KWIDTH-1:0]       k_q, k_d;
  logic                    busy_q, busy_d;
  logic [DWIDTH-1:0]       mem_q    [BDEPTH];
  logic [DWIDTH-1:0]       mem_d    [BDEPTH];
  logic [DWIDTH-1:0]       shadow_q [LANE];
  logic [DWIDTH-1:0]       shadow_d [LANE];
  logic [DWIDTH-1:0]       active_q [LANE];
  logic [DWIDTH-1:0]       active_d [LANE];
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_relu_q, s1_relu_d;
  logic [LANE*DWIDTH-1:0]  s1_pixel_q, s1_pixel_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANE*DWIDTH-1:0]  pixel_out_q, pixel_out_d;
  logic [AWIDTH-1:0]       fetch_addr;

  // Sum at DWIDTH+1 bits; the two top bits disagree exactly when the result overflows.
  function automatic logic [DWIDTH-1:0] bias_add(input logic [DWIDTH-1:0] px,
                                                 input logic [DWIDTH-1:0] b,
                                                 input logic              relu);
    logic [DWIDTH:0]   sum;
    logic [DWIDTH-1:0] res;
    sum = {px[DWIDTH-1], px} + {b[DWIDTH-1], b};
    if (sum[DWIDTH] != sum[DWIDTH-1])
      res = sum[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    else
      res = sum[DWIDTH-1:0];
    if (relu && res[DWIDTH-1])
      res = '0;
    return res;
  endfunction

  assign fetch_addr = base_q + AWIDTH'(k_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    k_d         = k_q;
    busy_d      = busy_q;
    mem_d       = mem_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    s1_valid_d  = in_valid;
    s1_relu_d   = relu_en;
    s1_pixel_d  = pixel_in;
    out_valid_d = 1'b0;
    pixel_out_d = pixel_out_q;

    case (state_q)
      IDLE: begin
        if (bsel_en) begin
          state_d = FETCH;
          base_d  = bsel_base;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        // The read uses mem_q, so a same-edge write to this address is not seen.
        shadow_d[k_q] = mem_q[fetch_addr];
        if (k_q == KWIDTH'(LANE - 1)) begin
          active_d = shadow_d;
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bias_we)
      mem_d[bias_addr] = bias_wdata;

    if (s1_valid_q) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < LANE; i++)
        pixel_out_d[i*DWIDTH +: DWIDTH] =
          bias_add(s1_pixel_q[i*DWIDTH +: DWIDTH], active_q[i], s1_relu_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      for (int a = 0; a < BDEPTH; a++)
        mem_q[a] <= '0;
      for (int i = 0; i < LANE; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_pixel_q  <= '0;
      out_valid_q <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      s1_valid_q  <= s1_valid_d;
      s1_relu_q   <= s1_relu_d;
      s1_pixel_q  <= s1_pixel_d;
      out_valid_q <= out_valid_d;
      pixel_out_q <= pixel_out_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign pixel_out = pixel_out_q;

endmodule

// File: doc/renkon_bias_bank.md
Name: renkon_bias_bank

Overview:
Multi-lane bias-add stage for the renkon post-accumulation datapath. It is the generalised successor of the single-lane bias adder. It holds a bias memory of BDEPTH entries and fetches LANE consecutive biases into per-lane shadow registers. The fetched set is swapped atomically into the active set, and the block adds the active biases to a LANE-wide pixel stream with saturation and optional ReLU.

Parameters:
DWIDTH, 16, pixel/bias width (signed two's complement)
LANE, 8, parallel pixel lanes (>=1)
BDEPTH, 32, bias memory entries (power of two, >=LANE)
AWIDTH, log2(BDEPTH), bias address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
bias_we  in  1  write bias_wdata to bias memory at bias_addr
bias_addr  in  AWIDTH  bias memory write address
bias_wdata  in  DWIDTH  signed bias write data
bsel_en  in  1  one-cycle pulse: start fetching LANE biases from bsel_base
bsel_base  in  AWIDTH  first bias index for lane 0
busy  out  1  fetch in progress
relu_en  in  1  clamp negative results to 0; sampled with in_valid
in_valid  in  1  pixel_in valid this cycle
pixel_in  in  LANE*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH], signed
out_valid  out  1  pixel_out updated this cycle
pixel_out  out  LANE*DWIDTH  biased pixels, same lane packing

Behaviour:
- Reset (rst=1 at clk edge): bias memory, shadow and active bias registers, pipeline registers, pixel_out, out_valid and busy all set to 0; FSM returns to IDLE. Reset has priority over every other input, including mid-fetch; a partially fetched shadow set is discarded.
- Bias memory write: registered write at the edge where bias_we=1; accepted in any FSM state.
- FSM states: IDLE, FETCH.
  - IDLE: bsel_en=1 latches bsel_base, sets fetch counter k=0 and moves to FETCH.
  - FETCH: each cycle, shadow[k] <= mem[(base+k) mod BDEPTH], then k++. After the edge that loads k=LANE-1, the shadow set is copied to the active set at that same edge and the FSM returns to IDLE.
- Fetch timing: bsel_en sampled at edge E0. busy=1 for exactly LANE cycles, covering edges E1..E_LANE. The new biases are active in the cycle after E_LANE.
- bsel_en while busy=1 is ignored; no queueing.
- Address wrap: index (base+k) is taken modulo BDEPTH, so base=BDEPTH-1 wraps to 0.
- Write/fetch collision: if the same address is written and fetched at the same edge, the fetch captures the old memory content.
- Datapath, 2-cycle latency:
  - Stage 1 registers pixel_in, relu_en and in_valid at every edge.
  - Stage 2, at the next edge: if stage-1 valid, pixel_out lane i <= f(r_pixel_in[i] + active[i]) and out_valid <= 1; otherwise out_valid <= 0 and pixel_out holds its value.
  - Stage 2 uses the active bias values present before that edge. Pixels are processed normally while busy=1, using the old active set until the swap.
- Arithmetic: sum is computed at DWIDTH+1 bits and saturated to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]. If the registered relu_en=1, negative saturated results become 0. Saturation is applied before ReLU.
- in_valid may be asserted every cycle (full throughput); there is no backpressure.

Test Plan:
(All tests use DWIDTH=16, LANE=4, BDEPTH=8.)
- Reset: hold rst 2 cycles with random inputs -> pixel_out=0, out_valid=0, busy=0. in_valid with pixel 5 on all lanes right after reset -> outputs 5,5,5,5 two cycles later (biases are 0).
- Basic fetch/add: write mem[0..7]=10,20,...,80; pulse bsel_en with base=0 -> busy high exactly 4 cycles. Then pixel 100 on all lanes -> pixel_out 110,120,130,140 with out_valid one cycle-pulse, 2 cycles after in_valid.
- Wrap and swap boundary: base=6 -> active becomes 70,80,10,20. Stream pixel 0 continuously through the fetch -> outputs switch from the old set to 70,80,10,20 exactly on the first result computed after the swap edge. A bsel_en pulse during busy has no effect.
- Saturation: mem[0]=1000, then pixel 32000 -> 32767. mem[0]=-1000, then pixel -32000 -> -32768. No wrap-around in either case.
- ReLU: bias 10, pixel -50 with relu_en=1 -> 0; same input with relu_en=0 -> -40. Toggling relu_en every cycle affects only its own beat.
- Reset mid-fetch and collision: assert rst on the 2nd busy cycle -> busy=0 next cycle, active biases 0. Write mem[2]=99 on the same edge that fetches address 2 (old value 30) -> lane uses 30.
